// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial shift controller.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register; zeros are shifted in behind the data.
module piso_shift_reg #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_en_i,
  input  logic             clear_i,
  output logic             ser_o
);

  logic [WIDTH-1:0] shreg;

  // Register update: reset, clear, load and shift in decreasing priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg <= '0;
    end else if (clear_i) begin
      shreg <= '0;
    end else if (load_i) begin
      shreg <= data_i;
    end else if (shift_en_i) begin
      if (LSB_FIRST) begin
        shreg <= {1'b0, shreg[WIDTH-1:1]};
      end else begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Output bit is taken straight from the end of the register.
  always_comb begin
    ser_o = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
  end

endmodule

// File: rtl/serial_shift_ctrl.sv
// Frame sequencer: accepts a word over valid/ready, shifts it out under a
// frame strobe, enforces an idle gap and counts completed frames.
module serial_shift_ctrl
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned GAP_CYCLES = 1,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] par_i,
  input  logic             par_valid_i,
  output logic             par_ready_o,
  input  logic             abort_i,
  output logic             x_o,
  output logic             frame_o,
  output logic             done_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  localparam int unsigned BW = cnt_width(WIDTH);
  localparam int unsigned GW = cnt_width(GAP_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  ser_state_t    state, next_state;
  logic [BW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          ready;
  logic          accept;
  logic          done;
  logic          frame;
  logic          last_bit;
  logic          ser_bit;

  piso_shift_reg #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load_i    (accept),
    .data_i    (par_i),
    .shift_en_i(state == SHIFT),
    .clear_i   ((state == SHIFT) && abort_i),
    .ser_o     (ser_bit)
  );

  // Handshake, strobes and next-state selection.
  // With no gap, the last bit cycle doubles as an accept slot so that the
  // next word is loaded on the same edge that retires the current one.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    done       = 1'b0;
    frame      = 1'b0;
    last_bit   = (state == SHIFT) && (bit_cnt == BIT_LAST);
    unique case (state)
      IDLE: begin
        ready = !abort_i;
        if (par_valid_i && ready) begin
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        frame = 1'b1;
        if (abort_i) begin
          next_state = IDLE;
        end else if (last_bit) begin
          done = 1'b1;
          if (GAP_CYCLES == 0) begin
            ready = 1'b1;
          end
          if (GAP_CYCLES == 0 && par_valid_i) begin
            next_state = SHIFT;
          end else if (GAP_CYCLES > 0) begin
            next_state = GAP;
          end else begin
            next_state = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    accept = par_valid_i && ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Bit position within the frame; restarts on every load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt <= '0;
    end else if (accept || state != SHIFT || abort_i || last_bit) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + BW'(1);
    end
  end

  // Idle-gap cycle counter, only advances while the gap continues.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gap_cnt <= '0;
    end else if (state == GAP && next_state == GAP) begin
      gap_cnt <= gap_cnt + GW'(1);
    end else begin
      gap_cnt <= '0;
    end
  end

  // Completed-frame counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt_o <= '0;
    end else if (done) begin
      frame_cnt_o <= frame_cnt_o + CNT_W'(1);
    end
  end

  // Output drive; serial data is forced low outside a frame.
  always_comb begin
    par_ready_o = ready;
    done_o      = done;
    frame_o     = frame;
    x_o         = frame ? ser_bit : 1'b0;
    busy_o      = (state != IDLE);
  end

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Directed bench for serial_shift_ctrl: three instances cover MSB-first with a
// gap, LSB-first, and back-to-back frames with a 2-bit counter.
module tb_serial_shift_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic [3:0] par [3];
  logic       vld [3];
  logic       abt [3];
  logic       x   [3];
  logic       frm [3];
  logic       dn  [3];
  logic       rdy [3];
  logic       bsy [3];
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int errors = 0;
  int checks = 0;

  serial_shift_ctrl #(.WIDTH(4), .GAP_CYCLES(1), .LSB_FIRST(1'b0), .CNT_W(8)) u_msb (
    .clk(clk), .reset(rst[0]), .par_i(par[0]), .par_valid_i(vld[0]), .par_ready_o(rdy[0]),
    .abort_i(abt[0]), .x_o(x[0]), .frame_o(frm[0]), .done_o(dn[0]), .busy_o(bsy[0]),
    .frame_cnt_o(cnt_a));

  serial_shift_ctrl #(.WIDTH(4), .GAP_CYCLES(1), .LSB_FIRST(1'b1), .CNT_W(8)) u_lsb (
    .clk(clk), .reset(rst[1]), .par_i(par[1]), .par_valid_i(vld[1]), .par_ready_o(rdy[1]),
    .abort_i(abt[1]), .x_o(x[1]), .frame_o(frm[1]), .done_o(dn[1]), .busy_o(bsy[1]),
    .frame_cnt_o(cnt_b));

  serial_shift_ctrl #(.WIDTH(4), .GAP_CYCLES(0), .LSB_FIRST(1'b0), .CNT_W(2)) u_b2b (
    .clk(clk), .reset(rst[2]), .par_i(par[2]), .par_valid_i(vld[2]), .par_ready_o(rdy[2]),
    .abort_i(abt[2]), .x_o(x[2]), .frame_o(frm[2]), .done_o(dn[2]), .busy_o(bsy[2]),
    .frame_cnt_o(cnt_c));

  // One cycle of stimulus for one instance plus the outputs expected in that
  // same cycle, packed as {x, frame, done, ready, busy, count[7:0]}.
  typedef struct {
    int          dut;
    logic        rs;
    logic [3:0]  p;
    logic        v;
    logic        ab;
    logic [12:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int d, logic rs, logic [3:0] p, logic v, logic ab,
                              logic ex, logic ef, logic ed, logic er, logic eb,
                              logic [7:0] ec);
    vec_t r;
    r.dut = d; r.rs = rs; r.p = p; r.v = v; r.ab = ab;
    r.exp = {ex, ef, ed, er, eb, ec};
    return r;
  endfunction

  function automatic logic [12:0] outs(int d);
    case (d)
      0:       return {x[0], frm[0], dn[0], rdy[0], bsy[0], cnt_a};
      1:       return {x[1], frm[1], dn[1], rdy[1], bsy[1], cnt_b};
      default: return {x[2], frm[2], dn[2], rdy[2], bsy[2], 6'b0, cnt_c};
    endcase
  endfunction

  // Idle every instance, then apply the given inputs to the selected one.
  task automatic drive(int d, logic rs, logic [3:0] p, logic v, logic ab);
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; par[i] = '0; vld[i] = 1'b0; abt[i] = 1'b0;
    end
    rst[d] = rs; par[d] = p; vld[d] = v; abt[d] = ab;
  endtask

  task automatic check(string name, int idx, logic [12:0] act, logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: x,frame,done,ready,busy,cnt got %b required %b", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] want;

    // Reset state of every instance.
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(2, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 0));
    // MSB first 1011, one gap cycle, par_i changed after accept.
    vq.push_back(mk(0, 1, 4'b1011, 1, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 1, 1, 0, 0, 1, 0));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 1, 1, 0, 0, 1, 0));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 1, 1, 1, 0, 1, 0));
    vq.push_back(mk(0, 1, 4'b0101, 1, 0, 0, 0, 0, 0, 1, 1));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 1));
    // Abort on the second bit of 1111, then abort blocking acceptance in IDLE.
    vq.push_back(mk(0, 1, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 1));
    vq.push_back(mk(0, 1, 4'b1111, 0, 0, 1, 1, 0, 0, 1, 1));
    vq.push_back(mk(0, 1, 4'b1111, 0, 1, 1, 1, 0, 0, 1, 1));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 1));
    vq.push_back(mk(0, 1, 4'b1111, 1, 1, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 1));
    // Abort on the last bit: no done, no count, straight back to IDLE.
    vq.push_back(mk(0, 1, 4'b1000, 1, 0, 0, 0, 0, 1, 0, 1));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 1, 1, 0, 0, 1, 1));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(mk(0, 1, 4'b0000, 0, 1, 0, 1, 0, 0, 1, 1));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 1));
    // Reset (with abort) on the third bit, then a fresh 1001 frame.
    vq.push_back(mk(0, 1, 4'b0110, 1, 0, 0, 0, 0, 1, 0, 1));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 1, 1, 0, 0, 1, 1));
    vq.push_back(mk(0, 0, 4'b0000, 0, 1, 1, 1, 0, 0, 1, 1));
    vq.push_back(mk(0, 1, 4'b1001, 1, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 1, 1, 0, 0, 1, 0));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 1, 1, 1, 0, 1, 0));
    vq.push_back(mk(0, 1, 4'b0000, 0, 1, 0, 0, 0, 0, 1, 1));
    vq.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 1));
    // LSB first 0110.
    vq.push_back(mk(1, 1, 4'b0110, 1, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 1, 4'b0000, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk(1, 1, 4'b0000, 0, 0, 1, 1, 0, 0, 1, 0));
    vq.push_back(mk(1, 1, 4'b0000, 0, 0, 1, 1, 0, 0, 1, 0));
    vq.push_back(mk(1, 1, 4'b0000, 0, 0, 0, 1, 1, 0, 1, 0));
    vq.push_back(mk(1, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 1));
    vq.push_back(mk(1, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 1));
    // No gap: 1000 then 0001 back-to-back with valid held high.
    vq.push_back(mk(2, 1, 4'b1000, 1, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(2, 1, 4'b0001, 1, 0, 1, 1, 0, 0, 1, 0));
    vq.push_back(mk(2, 1, 4'b0001, 1, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk(2, 1, 4'b0001, 1, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk(2, 1, 4'b0001, 1, 0, 0, 1, 1, 1, 1, 0));
    vq.push_back(mk(2, 1, 4'b0000, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(mk(2, 1, 4'b0000, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(mk(2, 1, 4'b0000, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(mk(2, 1, 4'b0000, 0, 0, 1, 1, 1, 1, 1, 1));
    vq.push_back(mk(2, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 2));

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; par[i] = '0; vld[i] = 1'b0; abt[i] = 1'b0;
    end
    repeat (2) @(negedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].dut, vq[i].rs, vq[i].p, vq[i].v, vq[i].ab);
      #1;
      check("vec", i, outs(vq[i].dut), vq[i].exp);
    end

    // Counter wrap on the 2-bit instance: five frames give 1,2,3,0,1.
    @(negedge clk);
    drive(2, 1'b0, 4'b0000, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drive(2, 1'b1, 4'b1010, 1'b1, 1'b0);
      #1;
      n = 0;
      while (!rdy[2] && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      @(negedge clk);
      drive(2, 1'b1, 4'b0000, 1'b0, 1'b0);
      #1;
      n = 0;
      while (!dn[2] && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("done_seen", k, 13'(dn[2]), 13'd1);
      @(negedge clk);
      #1;
      want = 2'(k);
      check("wrap_cnt", k, 13'(cnt_c), 13'(want));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_shift_ctrl.md
Name: serial_shift_ctrl

Overview:
- Sequencing controller for a parallel-in/serial-out shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, framed by a strobe.
- Enforces a programmable idle gap between frames and supports abort.
- Counts completed frames. Sits between a word producer and any serial sink of the kind exercised by the team's shift-register benches.

Parameters:
WIDTH, 4, bits per frame (>=2)
GAP_CYCLES, 1, idle cycles forced after each frame (0 allows back-to-back frames)
LSB_FIRST, 0, 0 = shift MSB first, 1 = shift LSB first
CNT_W, 8, width of completed-frame counter

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-low reset; sampled on posedge clk, reset==0 resets
par_i  input  WIDTH  parallel word to send
par_valid_i  input  1  producer has a word on par_i
par_ready_o  output  1  controller can accept a word this cycle
abort_i  input  1  synchronous abort of the current frame
x_o  output  1  serial data bit
frame_o  output  1  high while x_o carries a valid frame bit
done_o  output  1  single-cycle pulse during the last bit of a frame
busy_o  output  1  state != IDLE
frame_cnt_o  output  CNT_W  count of completed (non-aborted) frames, wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous, active-low.
- Reset (reset==0 at posedge), from any state including mid-frame:
  - state=IDLE, shift reg=0, bit_cnt=0, gap_cnt=0, frame_cnt_o=0.
  - Outputs: x_o=0, frame_o=0, done_o=0, busy_o=0, par_ready_o=1 from the first cycle after reset.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - par_ready_o=1, frame_o=0, x_o=0.
  - Accept = par_valid_i && par_ready_o at posedge: load par_i into the shift reg, bit_cnt=0, go to SHIFT.
- SHIFT:
  - frame_o=1.
  - x_o = shreg[WIDTH-1] (MSB first) or shreg[0] (LSB first), combinational from the register.
  - Each posedge: shift by one toward the output end, fill 0, bit_cnt++.
  - Latency: the first bit appears on x_o the cycle after the accept edge; the frame occupies exactly WIDTH cycles.
  - done_o=1 when bit_cnt==WIDTH-1 and abort_i==0.
  - At that edge: frame_cnt_o++ (wraps 2^CNT_W-1 -> 0). Next state is GAP if GAP_CYCLES>0, else IDLE.
- Back-to-back (GAP_CYCLES==0 only):
  - par_ready_o=1 during the last bit cycle.
  - If a word is accepted there, go directly to SHIFT with the new word; no frame_o dropout.
- GAP:
  - frame_o=0, x_o=0, par_ready_o=0.
  - Stays GAP_CYCLES cycles via gap_cnt, then IDLE.
- par_ready_o=0 in SHIFT (except as above) and in GAP. par_valid_i is ignored there; the producer must hold the word.
- abort_i:
  - In SHIFT: next state IDLE, shift reg cleared, no done_o, frame_cnt_o unchanged. Aborting on the last bit cycle also suppresses done_o and the count.
  - In IDLE: blocks acceptance that cycle (par_ready_o forced 0).
  - In GAP: ignored.
- Simultaneous reset and abort: reset wins.
- par_i changes after accept do not affect the frame in flight.

Decomposition:
- Shared package `serial_pkg`:
  - state enum `ser_state_t` {IDLE, SHIFT, GAP}.
  - Function for counter width: max(1, clog2(WIDTH)).
- One sub-module `piso_shift_reg`: WIDTH/LSB_FIRST params; ports clk, reset, load_i, data_i, shift_en_i, clear_i, ser_o.
- The controller holds the FSM, counters and handshake.

Test Plan:
1. WIDTH=4, GAP=1, MSB first; accept 4'b1011 at edge T:
   - x_o = 1,0,1,1 on cycles T+1..T+4; frame_o high exactly those 4 cycles.
   - done_o only at T+4; frame_cnt_o 0->1 after T+4.
   - par_ready_o low T+1..T+5, high at T+6.
2. LSB_FIRST=1, word 4'b0110 -> x_o = 0,1,1,0.
3. GAP=0; par_valid_i held high with 4'b1000 then 4'b0001:
   - 8 continuous frame_o cycles, x_o = 1,0,0,0,0,0,0,1.
   - Two done_o pulses; frame_cnt_o=2.
4. abort_i on the 2nd bit cycle of 4'b1111:
   - frame_o drops next cycle, no done_o, frame_cnt_o unchanged.
   - par_ready_o=1 the cycle after abort.
5. reset=0 on the 3rd bit cycle: next cycle all outputs at reset values, frame_cnt_o=0; after release a new word shifts correctly.
6. CNT_W=2; send 5 frames -> frame_cnt_o sequence 1,2,3,0,1.
